// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: active-low
// segment glyphs ({g,f,e,d,c,b,a}) and the scan sequencer state encoding.
package display_scan_ctrl_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/display_scan_ctrl_bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder. Non-BCD codes
// render as a dash so corrupt upstream data is visible on the board.
module bcd_to_7seg
    import display_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Glyph lookup; anything above 9 is an error indication
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment scan sequencer. Each digit slot starts with a
// short all-anodes-off window (anti-ghosting) followed by the lit window.
// Inputs are captured once per frame so a digit never tears mid-frame.
// All board-facing outputs are registered from the next-state values, so
// anode and segment lines change on the same edge.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int  NUM_DIGITS   = 4,
    parameter int  PRESCALE     = 50000,
    parameter int  BLANK_CYCLES = 16,
    localparam int IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                    clck,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] value_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    localparam int               PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0]    LAST_PRESC = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    LAST_BLANK = PW'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t                  state_q, state_d;
    logic [PW-1:0]                presc_q, presc_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         frame_done_q, frame_done_d;
    logic                         rst_ok_q;
    logic                         snap_load;
    logic [NUM_DIGITS-1:0][3:0]   snap_val_q, snap_val_d;
    logic [NUM_DIGITS-1:0]        snap_dp_q, snap_dp_d;
    logic                         snap_lz_q, snap_lz_d;
    logic [NUM_DIGITS-1:0]        supp;
    logic [NUM_DIGITS-1:0]        an_q, an_d;
    logic [6:0]                   seg_q, seg_d, dec_seg;
    logic                         dp_q, dp_d;
    logic                         all_zero;

    // Sequencer: slot timing, digit advance, frame wrap and snapshot strobe
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        snap_load    = 1'b0;
        if (!en) begin
            state_d = IDLE;
            presc_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                // rst_ok_q holds off the first edge after reset release
                IDLE: if (rst_ok_q) begin
                    state_d   = BLANK;
                    presc_d   = '0;
                    idx_d     = '0;
                    snap_load = 1'b1;
                end
                BLANK: begin
                    presc_d = presc_q + 1'b1;
                    if (presc_q == LAST_BLANK) state_d = SHOW;
                end
                SHOW: begin
                    if (presc_q == LAST_PRESC) begin
                        state_d = BLANK;
                        presc_d = '0;
                        if (idx_q == LAST_IDX) begin
                            idx_d        = '0;
                            frame_done_d = 1'b1;
                            snap_load    = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Frame snapshot captured at the start of digit 0's slot
    always_comb begin
        snap_val_d = snap_val_q;
        snap_dp_d  = snap_dp_q;
        snap_lz_d  = snap_lz_q;
        if (snap_load) begin
            snap_val_d = value_bcd;
            snap_dp_d  = dp_mask;
            snap_lz_d  = lz_blank;
        end
    end

    // Leading-zero mask: digit i dark when it and every higher digit are 0
    always_comb begin
        supp     = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (snap_val_q[i] == 4'd0);
            supp[i]  = snap_lz_q & all_zero & (i != 0);
        end
    end

    bcd_to_7seg u_dec (
        .bcd (snap_val_q[idx_d]),
        .seg (dec_seg)
    );

    // Output image for the coming cycle; dark unless entering/staying in SHOW
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == SHOW) begin
            an_d[idx_d] = 1'b0;
            seg_d       = supp[idx_d] ? SEG_OFF : dec_seg;
            dp_d        = ~snap_dp_q[idx_d];
        end
    end

    // State, snapshot and registered outputs
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            rst_ok_q     <= 1'b0;
            snap_val_q   <= '0;
            snap_dp_q    <= '0;
            snap_lz_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            rst_ok_q     <= 1'b1;
            snap_val_q   <= snap_val_d;
            snap_dp_q    <= snap_dp_d;
            snap_lz_q    <= snap_lz_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (4 digits, 8-cycle slots, 2 blank).
// Stimulus pushes the expected lit-digit sequence per frame; a monitor pops
// one entry at the start of every lit window and compares.
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int PS = 8;
    localparam int BC = 2;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
    } exp_t;

    logic        clck = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] value_bcd;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int   tests  = 0;
    int   fails  = 0;
    int   fd_seen = 0;
    int   exp_fd  = 0;
    bit   trunc   = 1'b0;
    exp_t sb[$];

    logic [3:0] prev_an = 4'hF;
    int         run_len = 0;

    always #5 clck = ~clck;

    display_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(PS), .BLANK_CYCLES(BC)) dut (
        .clck(clck), .rst_n(rst_n), .en(en), .value_bcd(value_bcd),
        .dp_mask(dp_mask), .lz_blank(lz_blank), .an(an), .seg(seg), .dp(dp),
        .digit_idx(digit_idx), .frame_done(frame_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h3F;
        endcase
    endfunction

    // Expected appearance of each digit for a frame, from the display rules
    task automatic push_frame(input logic [15:0] v, input logic [3:0] dpm, input logic lz);
        for (int d = 0; d < N; d++) begin
            exp_t        e;
            logic [15:0] upper;
            logic [3:0]  nib;
            upper  = v >> (4 * d);
            nib    = upper[3:0];
            e.an   = ~(4'b0001 << d);
            e.seg  = (lz && d > 0 && upper == 16'h0) ? 7'h7F : glyph(nib);
            e.dp   = ~dpm[d];
            e.idx  = 2'(d);
            sb.push_back(e);
        end
    endtask

    // One frame: load inputs before the snapshot edge, disturb them during
    // digit 1's lit window, optionally drop en at negedge 'cut'.
    task automatic run_frame(input logic [15:0] v, input logic [3:0] dpm, input logic lz,
                             input bit first, input int cut);
        int scr;
        scr       = $urandom_range(11, 15);
        en        = 1'b1;
        value_bcd = v;
        dp_mask   = dpm;
        lz_blank  = lz;
        push_frame(v, dpm, lz);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clck);
            if (k == 1) begin
                chk("frame_done_wrap", frame_done, first ? 1'b0 : 1'b1);
                if (!first) exp_fd++;
            end
            if (k == 2) begin
                chk("frame_done_width", frame_done, 0);
                chk("blank_before_show", an, 4'hF);
            end
            if (k == 3) chk("first_show_an", an, 4'hE);
            if (k == scr) begin
                value_bcd = 16'($urandom);
                dp_mask   = 4'($urandom);
                lz_blank  = 1'($urandom);
            end
            if (cut != 0 && k == cut) begin
                en = 1'b0;
                void'(sb.pop_back());
                trunc = 1'b1;
            end
            if (cut != 0 && k == cut + 1) begin
                chk("dis_an", an, 4'hF);
                chk("dis_seg", seg, 7'h7F);
                chk("dis_dp", dp, 1);
                chk("dis_idx", digit_idx, 0);
            end
            if (cut != 0 && k > cut) chk("dis_no_frame_done", frame_done, 0);
        end
    endtask

    // Monitor: checks dark windows, slot length and lit digits vs scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clck);
            #1;
            chk("an_single_low", ($countones(~an) <= 1) ? 1 : 0, 1);
            if (an == 4'hF) begin
                chk("dark_seg", seg, 7'h7F);
                chk("dark_dp", dp, 1);
                if (prev_an != 4'hF) begin
                    if (trunc) trunc = 1'b0;
                    else chk("show_len", run_len, PS - BC);
                end
                run_len = 0;
            end else if (prev_an == 4'hF) begin
                if (sb.size() == 0) begin
                    chk("unexpected_show_an", an, 4'hF);
                end else begin
                    e = sb.pop_front();
                    chk("show_an", an, e.an);
                    chk("show_seg", seg, e.seg);
                    chk("show_dp", dp, e.dp);
                    chk("show_idx", digit_idx, e.idx);
                end
                run_len = 1;
            end else begin
                chk("show_an_stable", an, prev_an);
                run_len++;
            end
            if (frame_done === 1'b1) fd_seen++;
            prev_an = an;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        rst_n     = 1'b0;
        en        = 1'b1;
        value_bcd = 16'h5555;
        dp_mask   = 4'h0;
        lz_blank  = 1'b0;
        #12;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        chk("rst_idx", digit_idx, 0);
        chk("rst_frame_done", frame_done, 0);
        @(negedge clck);
        rst_n = 1'b1;
        @(negedge clck);
        chk("idle_first_edge_an", an, 4'hF);

        run_frame(16'h1234, 4'h0, 1'b0, 1'b1, 0);
        run_frame(16'h1234, 4'h0, 1'b0, 1'b0, 0);
        run_frame(16'h9999, 4'h0, 1'b0, 1'b0, 0);
        run_frame(16'h0007, 4'h0, 1'b1, 1'b0, 0);
        run_frame(16'h0000, 4'h0, 1'b1, 1'b0, 0);
        run_frame(16'h0000, 4'h0, 1'b0, 1'b0, 0);
        run_frame(16'hA00F, 4'b0010, 1'b0, 1'b0, 0);
        run_frame(16'h000F, 4'b0010, 1'b1, 1'b0, 0);
        run_frame(16'h1234, 4'h0, 1'b0, 1'b0, 20);
        run_frame(16'h4321, 4'b1000, 1'b0, 1'b1, 0);

        for (int f = 0; f < 12; f++) begin
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v = v & 16'h0FFF;
                1: v = v & 16'h00FF;
                2: v = v & 16'h000F;
                default: ;
            endcase
            run_frame(v, 4'($urandom), 1'($urandom), 1'b0, 0);
        end

        // Asynchronous reset in the middle of operation
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", an, 4'hF);
        chk("async_rst_seg", seg, 7'h7F);
        chk("async_rst_idx", digit_idx, 0);
        @(negedge clck);
        rst_n = 1'b1;
        @(negedge clck);
        chk("post_rst_idle_an", an, 4'hF);
        run_frame(16'h0908, 4'b0101, 1'b1, 1'b1, 0);
        run_frame(16'h8765, 4'h0, 1'b0, 1'b0, 0);

        // Disable right before the wrap edge: no frame_done pulse
        en = 1'b0;
        repeat (6) @(negedge clck);
        chk("final_idle_an", an, 4'hF);
        chk("frame_done_count", fd_seen, exp_fd);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed driver for the parking-lot controller's seven-segment display bank. It replaces the free-running 2-bit digit counter with a full scan sequencer containing:
- a refresh prescaler;
- a digit index;
- anti-ghosting dead time;
- a frame-coherent snapshot of the displayed value;
- leading-zero suppression.
Its inputs come from the occupancy/vacancy BCD registers. Its outputs drive the board anodes and segments directly.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 = least significant
PRESCALE, 50000, clock cycles per digit slot (>= BLANK_CYCLES+2)
BLANK_CYCLES, 16, cycles at slot start with all anodes off (>= 1)

Ports:
clck  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 = display dark
value_bcd  in  4*NUM_DIGITS  BCD digits, nibble i = digit i
dp_mask  in  NUM_DIGITS  decimal point request per digit, 1 = lit
lz_blank  in  1  1 = suppress leading zeros
an  out  NUM_DIGITS  anode select, active-low, at most one bit low
seg  out  7  {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
digit_idx  out  clog2(NUM_DIGITS)  digit index of the current slot
frame_done  out  1  one-cycle pulse at end of last digit's slot

Behaviour:
Reset:
- Async assert on rst_n low: state IDLE, an all 1s, seg 7'h7F, dp 1, digit_idx 0, frame_done 0, prescaler 0, snapshot 0.
- Release is synchronous to clck.

State machine:
- IDLE -> BLANK when en=1, digit_idx=0, prescaler=0, snapshot loaded.
- BLANK: lasts BLANK_CYCLES cycles; an all 1s, seg 7'h7F, dp 1.
- BLANK -> SHOW after BLANK_CYCLES.
- SHOW: lasts PRESCALE-BLANK_CYCLES cycles. The low anode bit is an[digit_idx]. seg/dp are the decoded snapshot digit.
- End of SHOW (slot end) -> BLANK with digit_idx+1. Wraps NUM_DIGITS-1 -> 0.
- frame_done=1 on the clock edge of the wrap for one cycle.

Snapshot and suppression:
- Snapshot of value_bcd, dp_mask and lz_blank loads on every entry to BLANK with digit_idx=0 (including from IDLE). Mid-frame input changes are invisible until the next frame.
- Leading-zero suppression: digit i (i >= 1) is blank (seg 7'h7F) when snap_lz=1 and snapshot digits NUM_DIGITS-1..i are all 0. Digit 0 is never suppressed.
- dp follows snap_dp[i] even on a suppressed digit.

Decode:
- Glyphs 0..9: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
- Codes 10..15 show dash 7'h3F (error indication).
- Outputs are registered; seg/an change on the same edge, no glitches.

Enable:
- en=0 in any state -> IDLE on the next edge: an all 1s, seg 7'h7F, dp 1, digit_idx 0, prescaler 0. No frame_done pulse.
- Re-enable always restarts at digit 0 with a fresh snapshot.

Boundaries:
- Mid-operation reset returns to IDLE within the same cycle (async).
- en high at reset release: IDLE on the first edge, BLANK on the second.

Decomposition:
- Shared package: the segment glyph constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF) and the state encoding (IDLE, BLANK, SHOW).
- Sub-module: bcd_to_7seg, a purely combinational decoder; the registered outputs stay in display_scan_ctrl.

Test Plan:
Parameters for all scenarios: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
1. Reset and idle: rst_n=0 with en=1, then release -> an=4'hF, seg=7'h7F, dp=1 during reset. First BLANK begins 2 edges after release. First SHOW on an=4'hE is 2 cycles later.
2. Basic scan: value_bcd=16'h1234, lz_blank=0 -> a 6-cycle SHOW per digit, in order:
   - an=E seg=19 (digit 4);
   - an=D seg=30 (digit 3);
   - an=B seg=24 (digit 2);
   - an=7 seg=79 (digit 1).
   frame_done pulses every 32 cycles. an is never low on two bits at once.
3. Zero suppression: value_bcd=16'h0007, lz_blank=1 -> digit 0 seg=78; digits 1..3 seg=7F. With 16'h0000, digit 0 seg=40 and the rest 7F. With lz_blank=0, all zeros show 40.
4. Frame coherence: change value_bcd from 16'h1234 to 16'h9999 during digit 1's SHOW -> digits 2,3 still show 2,1. The next frame shows all 10.
5. Disable and resume: drop en during digit 2's SHOW -> next edge an=F, seg=7F, digit_idx=0, no frame_done. Re-raise en -> restart at digit 0 after 2 BLANK cycles.
6. Invalid BCD and dp: value_bcd=16'hA00F, dp_mask=4'b0010 -> digits 0 and 3 show 3F, digit 2 shows 40. dp=0 only while an=D, including when that digit is suppressed under lz_blank=1.
